// File: rtl/multiport_mem_requester.sv
// Initiator side of a multiport RAM: per-port load/store requests in, RAM bus
// driven from registered state, read data captured after the RAM read latency.
module multiport_mem_requester #(
    parameter int unsigned mem_size   = 4096,
    parameter int unsigned mem_width  = 12,
    parameter int unsigned addr_width = 12,
    parameter int unsigned port_count = 2,
    parameter int unsigned rd_lat     = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [port_count-1:0]            req_valid,
    output logic [port_count-1:0]            req_ready,
    input  logic [port_count-1:0]            req_write,
    input  logic [addr_width*port_count-1:0] req_addr,
    input  logic [mem_width*port_count-1:0]  req_wdata,
    output logic [port_count-1:0]            resp_valid,
    input  logic [port_count-1:0]            resp_ready,
    output logic [port_count-1:0]            resp_err,
    output logic [mem_width*port_count-1:0]  resp_rdata,
    output logic [addr_width*port_count-1:0] address,
    output logic [mem_width*port_count-1:0]  datain,
    output logic [port_count-1:0]            mem_write,
    input  logic [mem_width*port_count-1:0]  dataout
);

    localparam int unsigned CW = (rd_lat > 1) ? $clog2(rd_lat) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                          state_q [port_count];
    state_t                          state_d [port_count];
    logic [CW-1:0]                   cnt_q   [port_count];
    logic [CW-1:0]                   cnt_d   [port_count];
    logic [port_count-1:0]           wr_q, wr_d, err_q, err_d;
    logic [port_count-1:0]           mem_write_q, mem_write_d;
    logic [port_count-1:0]           resp_valid_q, resp_valid_d;
    logic [port_count-1:0]           resp_err_q, resp_err_d;
    logic [mem_width*port_count-1:0]  resp_rdata_q, resp_rdata_d;
    logic [addr_width*port_count-1:0] address_q, address_d;
    logic [mem_width*port_count-1:0]  datain_q, datain_d;
    logic [port_count-1:0]           lose;

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign address    = address_q;
    assign datain     = datain_q;
    assign mem_write  = mem_write_q;

    // Same-address conflict with a store among idle requesters: lower index wins.
    always_comb begin
        lose = '0;
        for (int p = 1; p < int'(port_count); p++) begin
            for (int q = 0; q < p; q++) begin
                if (req_valid[p] && req_valid[q] &&
                    state_q[p] == S_IDLE && state_q[q] == S_IDLE &&
                    req_addr[p*addr_width +: addr_width] == req_addr[q*addr_width +: addr_width] &&
                    (req_write[p] || req_write[q]))
                    lose[p] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < int'(port_count); p++)
            req_ready[p] = !reset && (state_q[p] == S_IDLE) && !lose[p];
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        err_d        = err_q;
        mem_write_d  = '0;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        address_d    = address_q;
        datain_d     = datain_q;
        for (int p = 0; p < int'(port_count); p++) begin
            case (state_q[p])
                S_IDLE: begin
                    if (req_valid[p] && req_ready[p]) begin
                        address_d[p*addr_width +: addr_width] = req_addr[p*addr_width +: addr_width];
                        datain_d[p*mem_width +: mem_width]    = req_wdata[p*mem_width +: mem_width];
                        wr_d[p]        = req_write[p];
                        err_d[p]       = 32'(req_addr[p*addr_width +: addr_width]) >= mem_size;
                        mem_write_d[p] = req_write[p] && !err_d[p];
                        state_d[p]     = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (wr_q[p] || err_q[p]) begin
                        resp_valid_d[p] = 1'b1;
                        resp_err_d[p]   = err_q[p];
                        resp_rdata_d[p*mem_width +: mem_width] = '0;
                        state_d[p]      = S_RESP;
                    end else begin
                        cnt_d[p]   = CW'(rd_lat - 1);
                        state_d[p] = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Last wait cycle is the one where RAM dataout is valid.
                    if (cnt_q[p] == '0) begin
                        resp_valid_d[p] = 1'b1;
                        resp_err_d[p]   = 1'b0;
                        resp_rdata_d[p*mem_width +: mem_width] = dataout[p*mem_width +: mem_width];
                        state_d[p]      = S_RESP;
                    end else begin
                        cnt_d[p] = cnt_q[p] - CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready[p]) begin
                        resp_valid_d[p] = 1'b0;
                        resp_err_d[p]   = 1'b0;
                        resp_rdata_d[p*mem_width +: mem_width] = '0;
                        state_d[p]      = S_IDLE;
                    end
                end
                default: state_d[p] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < int'(port_count); p++) begin
                state_q[p] <= S_IDLE;
                cnt_q[p]   <= '0;
            end
            wr_q         <= '0;
            err_q        <= '0;
            mem_write_q  <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= '0;
            resp_rdata_q <= '0;
            address_q    <= '0;
            datain_q     <= '0;
        end else begin
            for (int p = 0; p < int'(port_count); p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
            wr_q         <= wr_d;
            err_q        <= err_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            address_q    <= address_d;
            datain_q     <= datain_d;
        end
    end

endmodule

// File: tb/tb_multiport_mem_requester.sv
// Bench for multiport_mem_requester: directed vectors, one-cycle-latency RAM
// model, per-port response scoreboard popped by a monitor process.
module tb_multiport_mem_requester;

    localparam int unsigned MW = 12;
    localparam int unsigned AW = 12;
    localparam int unsigned PC = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [PC-1:0]       req_valid, req_ready, req_write;
    logic [AW*PC-1:0]    req_addr;
    logic [MW*PC-1:0]    req_wdata;
    logic [PC-1:0]       resp_valid, resp_ready, resp_err;
    logic [MW*PC-1:0]    resp_rdata;
    logic [AW*PC-1:0]    address;
    logic [MW*PC-1:0]    datain;
    logic [PC-1:0]       mem_write;
    logic [MW*PC-1:0]    dataout;

    typedef struct packed {
        logic          err;
        logic [MW-1:0] rdata;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;
    logic [MW-1:0] ram [4096];

    multiport_mem_requester #(
        .mem_size(3000), .mem_width(MW), .addr_width(AW), .port_count(PC), .rd_lat(1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .address(address), .datain(datain),
        .mem_write(mem_write), .dataout(dataout)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle registered read, writes on the same edge.
    initial for (int i = 0; i < 4096; i++) ram[i] = 12'(i * 3);
    always @(posedge clk) begin
        for (int p = 0; p < int'(PC); p++) begin
            if (mem_write[p]) ram[address[p*AW +: AW]] <= datain[p*MW +: MW];
            dataout[p*MW +: MW] <= ram[address[p*AW +: AW]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            for (int p = 0; p < int'(PC); p++) begin
                if (resp_valid[p] && resp_ready[p]) begin
                    exp_t e;
                    if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp port=%0d actual=valid required=none", p);
                    end else begin
                        e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
                        chk($sformatf("resp_err_p%0d", p), 32'(resp_err[p]), 32'(e.err));
                        chk($sformatf("resp_rdata_p%0d", p), 32'(resp_rdata[p*MW +: MW]), 32'(e.rdata));
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        resp_ready = '0;

        // 1: reset
        cyc(); cyc();
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        chk("rst_resp_rdata", 32'(resp_rdata), 0);
        chk("rst_address", 32'(address), 0);
        chk("rst_datain", 32'(datain), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        reset = 1'b0;
        #1 chk("post_rst_req_ready", 32'(req_ready), 32'h3);
        resp_ready = 2'b11;

        // 2: p0 store 0x001 <= 0x5F9
        sb0.push_back('{err: 1'b0, rdata: 12'h000});
        req_valid = 2'b01; req_write = 2'b01; req_addr[11:0] = 12'h001; req_wdata[11:0] = 12'h5F9;
        cyc();
        req_valid = '0;
        chk("st_mem_write", 32'(mem_write), 32'h1);
        chk("st_address", 32'(address[11:0]), 32'h001);
        chk("st_datain", 32'(datain[11:0]), 32'h5F9);
        cyc();
        chk("st_resp_valid", 32'(resp_valid[0]), 1);
        chk("st_resp_err", 32'(resp_err[0]), 0);
        cyc();

        // 3: p0 load 0x001 with resp_ready held low
        resp_ready = 2'b00;
        sb0.push_back('{err: 1'b0, rdata: 12'h5F9});
        req_valid = 2'b01; req_write = 2'b00; req_addr[11:0] = 12'h001;
        cyc();
        req_valid = '0;
        chk("ld_mem_write", 32'(mem_write), 0);
        cyc(); cyc();
        chk("ld_resp_valid", 32'(resp_valid[0]), 1);
        chk("ld_rdata", 32'(resp_rdata[11:0]), 32'h5F9);
        cyc(); cyc();
        chk("ld_hold_valid", 32'(resp_valid[0]), 1);
        chk("ld_hold_rdata", 32'(resp_rdata[11:0]), 32'h5F9);
        resp_ready = 2'b11;
        cyc();
        chk("ld_done_valid", 32'(resp_valid[0]), 0);
        chk("ld_done_ready", 32'(req_ready[0]), 1);

        // 4: both ports store to 0x004, p0 wins
        sb0.push_back('{err: 1'b0, rdata: 12'h000});
        sb1.push_back('{err: 1'b0, rdata: 12'h000});
        req_valid = 2'b11; req_write = 2'b11;
        req_addr = {12'h004, 12'h004}; req_wdata = {12'h008, 12'h004};
        #1 chk("cf_req_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b10;
        chk("cf_mem_write_p0", 32'(mem_write), 32'h1);
        #1 chk("cf_req_ready_retry", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        chk("cf_mem_write_p1", 32'(mem_write), 32'h2);
        chk("cf_address_p1", 32'(address[23:12]), 32'h004);
        chk("cf_datain_p1", 32'(datain[23:12]), 32'h008);
        cyc(); cyc();

        // 5: concurrent loads 0x004 / 0x007 (0x007 preloaded with 7*3)
        sb0.push_back('{err: 1'b0, rdata: 12'h008});
        sb1.push_back('{err: 1'b0, rdata: 12'h015});
        req_valid = 2'b11; req_write = 2'b00; req_addr = {12'h007, 12'h004};
        #1 chk("dl_req_ready", 32'(req_ready), 32'h3);
        cyc();
        req_valid = '0;
        chk("dl_mem_write", 32'(mem_write), 0);
        cyc(); cyc();
        chk("dl_resp_valid", 32'(resp_valid), 32'h3);
        cyc(); cyc();

        // 6a: p1 out-of-range load
        sb1.push_back('{err: 1'b1, rdata: 12'h000});
        req_valid = 2'b10; req_write = 2'b00; req_addr[23:12] = 12'hC00;
        cyc();
        req_valid = '0;
        chk("oor_mem_write", 32'(mem_write), 0);
        cyc();
        chk("oor_resp_valid", 32'(resp_valid[1]), 1);
        chk("oor_resp_err", 32'(resp_err[1]), 1);
        chk("oor_rdata", 32'(resp_rdata[23:12]), 0);
        cyc(); cyc();

        // 6b: reset during p0 WAIT drops the load
        req_valid = 2'b01; req_write = 2'b00; req_addr[11:0] = 12'h001;
        cyc();
        req_valid = '0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("drop_resp_valid", 32'(resp_valid[0]), 0);
            cyc();
        end

        chk("sb_drained", 32'(sb0.size() + sb1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
